clk_div_ctrl: RTL and testbench
===============================

// Module: clk_div_ctrl
// PURPOSE
//  Run-time controller for the divided-clock path. Owns the divide counter and output
//  clock, starts and stops it, and accepts new divide ratios over a valid/ready port.
//  Ratio changes and stops take effect only at a falling boundary of o_clk, so the
//  output never glitches and never has a truncated high phase.
//  Sits between the register/config logic and any logic clocked or enabled by o_clk.
// PARAMETERS
//  CNT_W        8  width of half-period count and counter
//  DEFAULT_DIV  4  half-period (i_clk cycles per o_clk phase) after reset; must be >= 1
// PORTS
//  i_clk        in   1      sole clock
//  i_rst        in   1      synchronous, active-high reset
//  i_en         in   1      level: 1 = run divided clock, 0 = stop (o_clk parks low)
//  i_cfg_valid  in   1      new half-period offered
//  i_cfg_div    in   CNT_W  requested half-period N (0 is illegal)
//  o_cfg_ready  out  1      controller can accept a config this cycle
//  o_cfg_err    out  1      1-cycle pulse: accepted config had N==0, discarded
//  o_div        out  CNT_W  half-period currently in use
//  o_clk        out  1      divided clock, period 2*N i_clk cycles, 50% duty
//  o_rise       out  1      1-cycle pulse, high in the same cycle o_clk becomes 1
//  o_fall       out  1      1-cycle pulse, high in the same cycle o_clk becomes 0
//  o_busy       out  1      state != IDLE
// BEHAVIOUR
//  Reset values: state=IDLE, cnt=0, o_clk=0, o_rise=o_fall=0, o_div=DEFAULT_DIV,
//   pending cleared, o_cfg_ready=1, o_cfg_err=0.
//  A reset asserted mid-operation discards the pending config and the running phase.
//  States:
//   IDLE -> RUN when i_en=1. On that edge cnt<=0 and o_clk<=0.
//   RUN -> IDLE when i_en=0 and o_clk=0. Parks immediately; only the low phase is cut.
//   RUN -> STOP when i_en=0 and o_clk=1.
//   STOP -> RUN when i_en returns to 1 before the fall. Counting is undisturbed.
//   STOP -> IDLE on the fall edge.
//  Counting (RUN and STOP):
//   If cnt==o_div-1: cnt<=0, o_clk<=~o_clk, and the matching o_rise/o_fall pulse fires.
//   Otherwise: cnt<=cnt+1.
//   First o_rise occurs N edges after entering RUN, e.g. N=4 gives a rise on the 4th edge.
//  Config handshake:
//   A transfer happens when i_cfg_valid & o_cfg_ready.
//   o_cfg_ready = !pending, and is registered.
//   N==0: o_cfg_err pulses the next cycle; nothing is stored and ready stays 1.
//   N!=0: the value is stored as pending and ready drops.
//  Applying the pending value:
//   IDLE: o_div<=pend on the next edge, and ready rises.
//   RUN/STOP: applied on the next o_fall edge (same edge as the cnt wrap). The
//    following low phase already uses the new N.
//   A config accepted on the same edge as a fall is not applied at that fall; it waits
//    for the next one.
//  Simultaneous events: stop and config in the same cycle are both honoured, so the new
//   o_div is applied at the stopping fall. An IDLE->RUN edge with a pending value
//   applies it on that same edge.
//  N=1 gives o_clk = i_clk/2. o_rise and o_fall then alternate every cycle.
//  Counter compare is full CNT_W width. cnt never exceeds o_div-1 because o_div only
//   changes when cnt is 0 or the block is idle.
// STRUCTURE
//  clk_div_pkg holds:
//   - typedef enum {IDLE, RUN, STOP} state_t;
//   - localparams for CNT_W default and DEFAULT_DIV.
//  Sub-module clk_div_core holds cnt, o_clk, the toggle compare and the rise/fall
//   pulses. Its inputs are run, div and restart.
//  clk_div_ctrl holds the FSM, the pending register and the handshake.
// TESTING
//  1. Reset, i_en=1 held, N=4: o_rise on edges 4,12,20; o_fall on 8,16; o_busy=1.
//  2. Running at N=4, send cfg N=2 mid-high-phase: ready drops, o_div stays 4 until the
//     fall. Then low=2, high=2, and ready returns 1.
//  3. i_en=0 during the high phase: state goes STOP; o_clk falls after the full phase,
//     then IDLE and o_busy=0. i_en=0 during the low phase gives IDLE next edge.
//  4. cfg N=0 while idle: o_cfg_err pulses 1 cycle; o_div is unchanged.
//     cfg N=1 then i_en=1: o_clk toggles every cycle.
//  5. cfg offered on the exact fall edge: applied one full period later.
//     Second valid while pending: not accepted (ready=0) until apply.
//  6. i_rst asserted with pending cfg and o_clk=1: next edge gives all reset values;
//     o_div=4, the pending value is lost, and o_clk=0.

Source files
------------

// File: rtl/clk_div_pkg.sv
// Shared types and defaults for the divided-clock controller.
package clk_div_pkg;

  localparam int CNT_W_DEF       = 8;
  localparam int DEFAULT_DIV_DEF = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    STOP = 2'd2
  } state_t;

endpackage

// File: rtl/clk_div_if.sv
// Configuration handshake carrying a new half-period into the controller.
interface clk_div_if #(
  parameter int CNT_W = 8
);

  logic             i_cfg_valid;
  logic [CNT_W-1:0] i_cfg_div;
  logic             o_cfg_ready;
  logic             o_cfg_err;

  modport master (
    output i_cfg_valid,
    output i_cfg_div,
    input  o_cfg_ready,
    input  o_cfg_err
  );

  modport slave (
    input  i_cfg_valid,
    input  i_cfg_div,
    output o_cfg_ready,
    output o_cfg_err
  );

endinterface

// File: rtl/clk_div_core.sv
// Divide counter and output clock: toggles o_clk every div cycles while run is set,
// parks low otherwise.
module clk_div_core #(
  parameter int CNT_W = 8
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             run,
  input  logic             restart,
  input  logic [CNT_W-1:0] div,
  output logic             o_clk,
  output logic             o_rise,
  output logic             o_fall,
  output logic             wrap
);

  logic [CNT_W-1:0] cnt;

  assign wrap = (cnt == div - CNT_W'(1));

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      cnt    <= '0;
      o_clk  <= 1'b0;
      o_rise <= 1'b0;
      o_fall <= 1'b0;
    end else begin
      o_rise <= 1'b0;
      o_fall <= 1'b0;
      // Parking only ever happens with o_clk already low, so no fall pulse is owed here.
      if (restart || !run) begin
        cnt   <= '0;
        o_clk <= 1'b0;
      end else if (wrap) begin
        cnt    <= '0;
        o_clk  <= ~o_clk;
        o_rise <= ~o_clk;
        o_fall <= o_clk;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/clk_div_ctrl.sv
// Run-time controller for the divided clock: start/stop FSM, pending ratio register
// and config handshake; ratio changes and stops land only on a falling edge of o_clk.
module clk_div_ctrl
  import clk_div_pkg::*;
#(
  parameter int CNT_W       = CNT_W_DEF,
  parameter int DEFAULT_DIV = DEFAULT_DIV_DEF
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_en,
  clk_div_if.slave         cfg,
  output logic [CNT_W-1:0] o_div,
  output logic             o_clk,
  output logic             o_rise,
  output logic             o_fall,
  output logic             o_busy
);

  state_t           state_q, state_d;
  logic             run, restart, wrap;
  logic             pending_q, err_q;
  logic [CNT_W-1:0] pend_q, div_q;
  logic             fall_now, accept, apply, cfg_zero;

  clk_div_core #(.CNT_W(CNT_W)) u_core (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .run     (run),
    .restart (restart),
    .div     (div_q),
    .o_clk   (o_clk),
    .o_rise  (o_rise),
    .o_fall  (o_fall),
    .wrap    (wrap)
  );

  always_ff @(posedge i_clk) begin
    if (i_rst) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // A low phase may be cut short; a high phase always runs to its wrap before parking.
  always_comb begin
    state_d = state_q;
    run     = 1'b0;
    restart = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (i_en) begin
          state_d = RUN;
          restart = 1'b1;
        end
      end
      RUN: begin
        run = 1'b1;
        if (!i_en) begin
          if (!o_clk) begin
            state_d = IDLE;
            run     = 1'b0;
          end else if (wrap) begin
            state_d = IDLE;
          end else begin
            state_d = STOP;
          end
        end
      end
      STOP: begin
        run = 1'b1;
        if (i_en)      state_d = RUN;
        else if (wrap) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign fall_now = run & wrap & o_clk;
  assign accept   = cfg.i_cfg_valid & ~pending_q;
  assign cfg_zero = (cfg.i_cfg_div == '0);
  // pending_q is only set by an accept, which requires it clear, so the two never collide.
  assign apply    = pending_q & ((state_q == IDLE) | fall_now);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      pending_q <= 1'b0;
      err_q     <= 1'b0;
      div_q     <= CNT_W'(DEFAULT_DIV);
    end else begin
      err_q <= accept & cfg_zero;
      if (apply) begin
        div_q     <= pend_q;
        pending_q <= 1'b0;
      end else if (accept && !cfg_zero) begin
        pending_q <= 1'b1;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (accept && !cfg_zero) pend_q <= cfg.i_cfg_div;
  end

  assign cfg.o_cfg_ready = ~pending_q;
  assign cfg.o_cfg_err   = err_q;
  assign o_div           = div_q;
  assign o_busy          = (state_q != IDLE);

endmodule

// File: tb/tb_clk_div_ctrl.sv
// Bench for clk_div_ctrl: directed scenarios then random traffic against a
// phase-countdown reference model.
module tb_clk_div_ctrl;

  localparam int CNT_W = 8;
  localparam int DEF   = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic             en;
  logic [CNT_W-1:0] o_div;
  logic             o_clk, o_rise, o_fall, o_busy;

  clk_div_if #(.CNT_W(CNT_W)) cfg_if ();

  clk_div_ctrl #(.CNT_W(CNT_W), .DEFAULT_DIV(DEF)) dut (
    .i_clk  (clk),
    .i_rst  (rst),
    .i_en   (en),
    .cfg    (cfg_if),
    .o_div  (o_div),
    .o_clk  (o_clk),
    .o_rise (o_rise),
    .o_fall (o_fall),
    .o_busy (o_busy)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;

  // Reference model: active flag, output level, edges left before next toggle,
  // ratio in use and a one-deep queue of accepted ratios.
  bit m_act, m_lvl, m_rise, m_fall, m_err;
  int m_left, m_div;
  int m_pq[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d want %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic void model_step(input bit r, input bit e, input bit v, input int d);
    bit acc;
    if (r) begin
      m_act = 0; m_lvl = 0; m_left = 0; m_div = DEF;
      m_pq.delete();
      m_err = 0; m_rise = 0; m_fall = 0;
      return;
    end
    acc    = v && (m_pq.size() == 0);
    m_rise = 0;
    m_fall = 0;
    if (!m_act) begin
      if (m_pq.size() > 0) m_div = m_pq.pop_front();
      if (e) begin
        m_act  = 1;
        m_lvl  = 0;
        m_left = m_div;
      end
    end else if (!e && !m_lvl) begin
      m_act = 0;
    end else begin
      m_left--;
      if (m_left == 0) begin
        m_lvl  = !m_lvl;
        m_rise = m_lvl;
        m_fall = !m_lvl;
        if (m_fall && m_pq.size() > 0) m_div = m_pq.pop_front();
        m_left = m_div;
        if (m_fall && !e) m_act = 0;
      end
    end
    m_err = acc && (d == 0);
    if (acc && d != 0) m_pq.push_back(d);
  endfunction

  task automatic check_all();
    check("clk",   {31'd0, o_clk},  {31'd0, m_lvl});
    check("rise",  {31'd0, o_rise}, {31'd0, m_rise});
    check("fall",  {31'd0, o_fall}, {31'd0, m_fall});
    check("div",   {24'd0, o_div},  m_div);
    check("busy",  {31'd0, o_busy}, {31'd0, m_act});
    check("ready", {31'd0, cfg_if.o_cfg_ready}, {31'd0, (m_pq.size() == 0)});
    check("err",   {31'd0, cfg_if.o_cfg_err},   {31'd0, m_err});
  endtask

  task automatic cyc(input bit r, input bit e, input bit v, input int d);
    rst                = r;
    en                 = e;
    cfg_if.i_cfg_valid = v;
    cfg_if.i_cfg_div   = CNT_W'(d);
    @(posedge clk);
    model_step(r, e, v, d);
    #1;
    check_all();
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_clk"},   {31'd0, o_clk}, 32'd0);
    check({tag, "_div"},   {24'd0, o_div}, DEF);
    check({tag, "_ready"}, {31'd0, cfg_if.o_cfg_ready}, 32'd1);
    check({tag, "_busy"},  {31'd0, o_busy}, 32'd0);
    check({tag, "_err"},   {31'd0, cfg_if.o_cfg_err}, 32'd0);
  endtask

  initial begin
    bit r_en;
    rst = 1'b1; en = 1'b0;
    cfg_if.i_cfg_valid = 1'b0;
    cfg_if.i_cfg_div   = '0;

    // Reset, then enable held at N=4: rises at 4,12,20, falls at 8,16.
    cyc(1, 0, 0, 0);
    check_reset_values("rst");
    for (int e = 0; e <= 20; e++) begin
      cyc(0, 1, 0, 0);
      check("t1_rise", {31'd0, o_rise}, {31'd0, (e == 4 || e == 12 || e == 20)});
      check("t1_fall", {31'd0, o_fall}, {31'd0, (e == 8 || e == 16)});
    end

    // New ratio mid-high-phase holds until the fall.
    cyc(1, 0, 0, 0);
    for (int e = 0; e <= 5; e++) cyc(0, 1, 0, 0);
    cyc(0, 1, 1, 2);
    check("t2_ready", {31'd0, cfg_if.o_cfg_ready}, 32'd0);
    check("t2_div_hold", {24'd0, o_div}, 32'd4);
    for (int e = 0; e < 14; e++) cyc(0, 1, 0, 0);
    check("t2_div_new", {24'd0, o_div}, 32'd2);

    // Stop in high phase, then stop in low phase.
    cyc(1, 0, 0, 0);
    for (int e = 0; e <= 5; e++) cyc(0, 1, 0, 0);
    for (int e = 0; e < 5; e++) cyc(0, 0, 0, 0);
    check("t3_idle", {31'd0, o_busy}, 32'd0);
    for (int e = 0; e <= 2; e++) cyc(0, 1, 0, 0);
    cyc(0, 0, 0, 0);
    check("t3_park", {31'd0, o_busy}, 32'd0);

    // Illegal zero ratio, then N=1.
    cyc(0, 0, 1, 0);
    check("t4_err", {31'd0, cfg_if.o_cfg_err}, 32'd1);
    cyc(0, 0, 1, 1);
    check("t4_err_gone", {31'd0, cfg_if.o_cfg_err}, 32'd0);
    for (int e = 0; e < 8; e++) cyc(0, 1, 0, 0);

    // Config on the fall edge, and a second offer while pending.
    cyc(1, 0, 0, 0);
    for (int e = 0; e <= 7; e++) cyc(0, 1, 0, 0);
    cyc(0, 1, 1, 3);
    cyc(0, 1, 1, 5);
    check("t5_blocked", {31'd0, cfg_if.o_cfg_ready}, 32'd0);
    for (int e = 0; e < 20; e++) cyc(0, 1, 0, 0);

    // Reset with a pending value and o_clk high.
    cyc(1, 0, 0, 0);
    for (int e = 0; e <= 5; e++) cyc(0, 1, 0, 0);
    cyc(0, 1, 1, 7);
    cyc(1, 1, 0, 0);
    check_reset_values("t6");

    // Random traffic.
    r_en = 1'b0;
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 29) == 0) r_en = !r_en;
      cyc(($urandom_range(0, 399) == 0), r_en,
          ($urandom_range(0, 5) == 0), int'($urandom_range(0, 6)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
